axis_pkt_fifo: RTL and testbench

Store-and-forward AXI4-Stream packet FIFO, directly downstream of the two-input stream arbiter. It absorbs the arbiter's merged 8-bit stream and releases a packet to the master side only once its tlast beat is stored. The arbiter does not honour backpressure, so this block always accepts input and drops whole packets on overflow. It never emits a truncated packet.

---
 rtl/axis_pkg.sv | 25 ++
 rtl/axis_fifo_ram.sv | 35 +++
 rtl/axis_pkt_fifo.sv | 130 +++++++++++++
 tb/tb_axis_pkt_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet FIFO slice.
// Provides the default stream data width, the write-side FSM state type
// and a clog2 helper used to derive address widths from depths.
package axis_pkg;

  localparam int AXIS_DATA_W = 8;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: DEPTH words of WIDTH bits,
// synchronous write, asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk      write clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data (combinational from rd_addr)
import axis_pkg::*;

module axis_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int WIDTH  = AXIS_DATA_W + 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO. Always accepts input; a packet
// becomes visible on the master side only after its tlast beat is stored.
// A packet that does not fit is dropped whole and counted.
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_axis_tvalid/tready/tdata/tlast   slave stream (tready is constant 1)
//   m_axis_tvalid/tready/tdata/tlast   master stream (data/last 0 when idle)
//   pkt_count             complete packets stored and not yet fully read
//   drop_pulse            one-cycle pulse after a packet is discarded
//   drop_cnt              saturating count of dropped packets
import axis_pkg::*;

module axis_pkt_fifo #(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [ADDR_W:0]   pkt_count,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;     // speculative: includes the packet being written
  logic [PTR_W-1:0] wr_commit;  // end of the last complete packet
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] used;
  logic             full;
  logic             wr_en;
  logic             commit;
  logic             rd_fire;
  logic             rd_last;
  logic [DATA_W:0]  rd_word;
  wr_state_t        state;

  assign s_axis_tready = 1'b1;

  // Occupancy counts uncommitted beats too; a same-cycle read does not free space.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == FULL_LVL);
  assign wr_en   = s_axis_tvalid && (state == ACCEPT) && !full;
  assign commit  = wr_en && s_axis_tlast;

  assign m_axis_tvalid = (rd_ptr != wr_commit);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word[DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & rd_word[DATA_W];
  assign rd_fire       = m_axis_tvalid & m_axis_tready;
  assign rd_last       = rd_fire & rd_word[DATA_W];

  axis_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (DATA_W + 1)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= 1'b0;

      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      // Commit and tlast read in the same cycle cancel out.
      if (commit && !rd_last) begin
        pkt_count <= pkt_count + 1'b1;
      end else if (rd_last && !commit) begin
        pkt_count <= pkt_count - 1'b1;
      end

      case (state)
        ACCEPT: begin
          if (s_axis_tvalid) begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (s_axis_tlast) begin
                wr_commit <= wr_ptr + 1'b1;
              end
            end else begin
              // Overflow: discard the partial packet by rewinding to the last commit.
              wr_ptr     <= wr_commit;
              drop_pulse <= 1'b1;
              if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
              end
              if (!s_axis_tlast) begin
                state <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            state <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based packet model.
module tb_axis_pkt_fifo;

  localparam int DEPTH = 16;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tlast = 1'b0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic [4:0] pkt_count;
  logic       drop_pulse;
  logic [15:0] drop_cnt;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH),
    .ADDR_W (4),
    .CNT_W  (16)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count),
    .drop_pulse    (drop_pulse),
    .drop_cnt      (drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: complete packets waiting for readout, the packet
  // currently being received, and drop bookkeeping.
  logic [8:0] ready_q[$];
  logic [8:0] part_q[$];
  bit         dropping = 1'b0;
  int         exp_drops = 0;
  bit         exp_pulse = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pkts();
    int n;
    n = 0;
    foreach (ready_q[i]) if (ready_q[i][8]) n++;
    return n;
  endfunction

  task automatic check_outputs();
    logic       ev;
    logic [7:0] ed;
    logic       el;
    ev = (ready_q.size() > 0);
    ed = ev ? ready_q[0][7:0] : 8'h00;
    el = ev ? ready_q[0][8] : 1'b0;
    check_eq("tvalid", 32'(m_axis_tvalid), 32'(ev));
    check_eq("tdata", 32'(m_axis_tdata), 32'(ed));
    check_eq("tlast", 32'(m_axis_tlast), 32'(el));
    check_eq("pkt_count", 32'(pkt_count), 32'(model_pkts()));
    check_eq("drop_pulse", 32'(drop_pulse), 32'(exp_pulse));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit rdy);
    int stored;
    stored = ready_q.size() + part_q.size();
    exp_pulse = 1'b0;
    if (rdy && ready_q.size() > 0) void'(ready_q.pop_front());
    if (v) begin
      if (dropping) begin
        if (l) dropping = 1'b0;
      end else if (stored == DEPTH) begin
        part_q.delete();
        exp_pulse = 1'b1;
        if (exp_drops < 65535) exp_drops++;
        if (!l) dropping = 1'b1;
      end else begin
        part_q.push_back({l, d});
        if (l) begin
          foreach (part_q[i]) ready_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit rdy);
    @(negedge aclk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    m_axis_tready = rdy;
    #1;
    check_outputs();
    @(posedge aclk);
    model_step(v, d, l, rdy);
  endtask

  task automatic send_pkt(input logic [7:0] base, input int len, input bit rdy);
    for (int i = 0; i < len; i++) cycle(1'b1, base + 8'(i), (i == len - 1), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
  endtask

  // Reset is asserted between clock edges to show the outputs clear asynchronously.
  task automatic do_reset();
    @(negedge aclk);
    #2;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    areset = 1'b1;
    #1;
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_eq("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    check_eq("tready_const", 32'(s_axis_tready), 32'd1);
    ready_q.delete();
    part_q.delete();
    dropping  = 1'b0;
    exp_drops = 0;
    exp_pulse = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single packet, latency and pkt_count 0->1->0.
    send_pkt(8'hA0, 4, 1'b1);
    idle(6, 1'b1);

    // Fill to DEPTH, then overflow with a 3-beat packet; drain.
    send_pkt(8'h00, 16, 1'b0);
    send_pkt(8'h20, 3, 1'b0);
    idle(20, 1'b1);

    // Oversized packet followed by a short one.
    send_pkt(8'h80, 20, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Backpressure with tready toggling.
    send_pkt(8'hB0, 3, 1'b0);
    send_pkt(8'hC0, 3, 1'b0);
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b0, (i % 2) == 0);

    // Commit and tlast read in the same cycle.
    cycle(1'b1, 8'h31, 1'b1, 1'b0);
    cycle(1'b1, 8'h32, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset mid-packet with a stored packet pending.
    cycle(1'b1, 8'h40, 1'b1, 1'b0);
    cycle(1'b1, 8'h50, 1'b0, 1'b0);
    cycle(1'b1, 8'h51, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic: a congested phase then a balanced phase.
    for (int i = 0; i < 1500; i++) begin
      bit rdy;
      rdy = (i < 750) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
      cycle($urandom_range(9) < 7, 8'($urandom), $urandom_range(5) == 0, rdy);
    end
    idle(40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
